uio_axi_pkt_conv: RTL and testbench

UIO_AXI_PKT_CONV -- requirements
Module: uio_axi_pkt_conv

---
 rtl/uio_axi_pkg.sv | 20 ++
 rtl/uio_sync_fifo.sv | 57 +++++
 rtl/uio_axi_pkt_conv.sv | 146 ++++++++++++++
 tb/tb_uio_axi_pkt_conv.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uio_axi_pkg.sv
// Shared defaults and sizing helpers for the UIO <-> AXI-stream packet converter.
package uio_axi_pkg;

    localparam int UIO_W_DEF        = 128;
    localparam int AXI_W_DEF        = 64;
    localparam int PKT_BEATS_DEF    = 8;
    localparam int AFULL_MARGIN_DEF = 4;
    localparam int FIFO_DEPTH_DEF   = 16;

    // Number of AXI beats carried by one UIO word.
    function automatic int ratio(input int uio_w, input int axi_w);
        return uio_w / axi_w;
    endfunction

    // Width of a counter that spans 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uio_sync_fifo.sv
// First-word-fall-through synchronous FIFO with synchronous flush and free-entry count.
module uio_sync_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic          empty_o,
    output logic [AW:0]   free_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q, wr_d, rd_d;
    logic [AW:0]  count;
    logic         push_ok, pop_ok;

    assign count   = wr_q - rd_q;
    assign empty_o = (count == '0);
    assign free_o  = (AW+1)'(DEPTH) - count;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign pop_ok  = pop_i && !empty_o && !flush_i;
    assign push_ok = push_i && !flush_i && ((count != (AW+1)'(DEPTH)) || pop_ok);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) wr_d = wr_q + 1'b1;
        if (pop_ok)  rd_d = rd_q + 1'b1;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uio_axi_pkt_conv.sv
// UIO <-> AXI-stream packet converter: request words are split into packetized tx beats,
// rx beats are reassembled into response words with framing checks.
module uio_axi_pkt_conv
    import uio_axi_pkg::*;
#(
    parameter int UIO_W        = UIO_W_DEF,
    parameter int AXI_W        = AXI_W_DEF,
    parameter int PKT_BEATS    = PKT_BEATS_DEF,
    parameter int RQ_DEPTH     = FIFO_DEPTH_DEF,
    parameter int RS_DEPTH     = FIFO_DEPTH_DEF,
    parameter int AFULL_MARGIN = AFULL_MARGIN_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_stat_chan_up,
    input  logic               uio_rq_vld,
    input  logic [UIO_W-1:0]   uio_rq_data,
    output logic               uio_rq_afull,
    output logic [AXI_W-1:0]   o_s_axi_tx_tdata,
    output logic [AXI_W/8-1:0] o_s_axi_tx_tkeep,
    output logic               o_s_axi_tx_tlast,
    output logic               o_s_axi_tx_tvalid,
    input  logic               i_s_axi_tx_tready,
    input  logic [AXI_W-1:0]   i_m_axi_rx_tdata,
    input  logic [AXI_W/8-1:0] i_m_axi_rx_tkeep,
    input  logic               i_m_axi_rx_tlast,
    input  logic               i_m_axi_rx_tvalid,
    output logic               o_m_axi_rx_tready,
    output logic               uio_rs_vld,
    output logic [UIO_W-1:0]   uio_rs_data,
    input  logic               uio_rs_rdy,
    output logic               o_rx_err
);

    localparam int R     = ratio(UIO_W, AXI_W);
    localparam int SW    = cnt_width(R);
    localparam int BW    = cnt_width(PKT_BEATS);
    localparam int RQ_AW = $clog2(RQ_DEPTH);
    localparam int RS_AW = $clog2(RS_DEPTH);
    localparam logic [AXI_W/8-1:0] KEEP_ALL = '1;

    logic [UIO_W-1:0] rq_word, asm_word;
    logic             rq_empty, rq_pop, rs_empty, rs_push;
    logic [RQ_AW:0]   rq_free;
    logic [RS_AW:0]   rs_free;
    logic             tx_fire, rx_fire, rx_last_slot, rx_bad;
    logic [AXI_W-1:0] rq_slices [R];

    logic [SW-1:0]    tx_slice_q, tx_slice_d, rx_slice_q, rx_slice_d;
    logic [BW-1:0]    tx_beat_q, tx_beat_d, rx_beat_q, rx_beat_d;
    logic [UIO_W-1:0] rx_word_q, rx_word_d;
    logic             rx_err_q, rx_err_d;

    uio_sync_fifo #(.W(UIO_W), .DEPTH(RQ_DEPTH)) u_rq_fifo (
        .clk_i(clk), .rst_ni(reset_n), .flush_i(!i_stat_chan_up),
        .push_i(uio_rq_vld), .data_i(uio_rq_data), .pop_i(rq_pop),
        .data_o(rq_word), .empty_o(rq_empty), .free_o(rq_free)
    );

    uio_sync_fifo #(.W(UIO_W), .DEPTH(RS_DEPTH)) u_rs_fifo (
        .clk_i(clk), .rst_ni(reset_n), .flush_i(!i_stat_chan_up),
        .push_i(rs_push), .data_i(asm_word), .pop_i(uio_rs_rdy),
        .data_o(uio_rs_data), .empty_o(rs_empty), .free_o(rs_free)
    );

    for (genvar g = 0; g < R; g++) begin : g_slice
        assign rq_slices[g] = rq_word[g*AXI_W +: AXI_W];
    end

    // Flow-control flags are forced to their safe values while reset is held.
    assign uio_rq_afull      = !reset_n || !i_stat_chan_up || (rq_free <= (RQ_AW+1)'(AFULL_MARGIN));
    assign o_m_axi_rx_tready = reset_n && i_stat_chan_up && (rs_free > (RS_AW+1)'(AFULL_MARGIN));
    assign uio_rs_vld        = !rs_empty;
    assign o_rx_err          = rx_err_q;

    assign o_s_axi_tx_tvalid = !rq_empty;
    assign o_s_axi_tx_tdata  = o_s_axi_tx_tvalid ? rq_slices[tx_slice_q] : '0;
    assign o_s_axi_tx_tkeep  = o_s_axi_tx_tvalid ? KEEP_ALL : '0;
    assign o_s_axi_tx_tlast  = o_s_axi_tx_tvalid && (tx_beat_q == BW'(PKT_BEATS-1));

    assign tx_fire      = o_s_axi_tx_tvalid && i_s_axi_tx_tready;
    assign rq_pop       = tx_fire && (tx_slice_q == SW'(R-1));
    assign rx_fire      = i_m_axi_rx_tvalid && o_m_axi_rx_tready;
    assign rx_last_slot = (rx_slice_q == SW'(R-1));
    assign rx_bad       = (i_m_axi_rx_tlast != (rx_beat_q == BW'(PKT_BEATS-1)))
                       || (i_m_axi_rx_tkeep != KEEP_ALL);
    assign rs_push      = rx_fire && rx_last_slot;

    always_comb begin
        asm_word = rx_word_q;
        for (int k = 0; k < R; k++) begin
            if (rx_slice_q == SW'(k)) asm_word[k*AXI_W +: AXI_W] = i_m_axi_rx_tdata;
        end
    end

    always_comb begin
        tx_slice_d = tx_slice_q;
        tx_beat_d  = tx_beat_q;
        rx_slice_d = rx_slice_q;
        rx_beat_d  = rx_beat_q;
        rx_word_d  = rx_word_q;
        rx_err_d   = 1'b0;
        if (tx_fire) begin
            tx_slice_d = rq_pop ? '0 : tx_slice_q + 1'b1;
            tx_beat_d  = (tx_beat_q == BW'(PKT_BEATS-1)) ? '0 : tx_beat_q + 1'b1;
        end
        if (rx_fire) begin
            rx_slice_d = rx_last_slot ? '0 : rx_slice_q + 1'b1;
            rx_beat_d  = (rx_beat_q == BW'(PKT_BEATS-1)) ? '0 : rx_beat_q + 1'b1;
            rx_word_d  = rx_last_slot ? '0 : asm_word;
            // A bad beat is still consumed (and may complete a word); assembly restarts after it.
            if (rx_bad) begin
                rx_slice_d = '0;
                rx_beat_d  = '0;
                rx_word_d  = '0;
                rx_err_d   = 1'b1;
            end
        end
        if (!i_stat_chan_up) begin
            tx_slice_d = '0;
            tx_beat_d  = '0;
            rx_slice_d = '0;
            rx_beat_d  = '0;
            rx_word_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_slice_q <= '0;
            tx_beat_q  <= '0;
            rx_slice_q <= '0;
            rx_beat_q  <= '0;
            rx_word_q  <= '0;
            rx_err_q   <= 1'b0;
        end else begin
            tx_slice_q <= tx_slice_d;
            tx_beat_q  <= tx_beat_d;
            rx_slice_q <= rx_slice_d;
            rx_beat_q  <= rx_beat_d;
            rx_word_q  <= rx_word_d;
            rx_err_q   <= rx_err_d;
        end
    end

endmodule

// File: tb/tb_uio_axi_pkt_conv.sv
// Bench for uio_axi_pkt_conv: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uio_axi_pkt_conv;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         i_stat_chan_up = 1'b1;
    logic         uio_rq_vld = 1'b0;
    logic [127:0] uio_rq_data = '0;
    logic         uio_rq_afull;
    logic [63:0]  o_s_axi_tx_tdata;
    logic [7:0]   o_s_axi_tx_tkeep;
    logic         o_s_axi_tx_tlast, o_s_axi_tx_tvalid;
    logic         i_s_axi_tx_tready = 1'b0;
    logic [63:0]  i_m_axi_rx_tdata = '0;
    logic [7:0]   i_m_axi_rx_tkeep = 8'hFF;
    logic         i_m_axi_rx_tlast = 1'b0;
    logic         i_m_axi_rx_tvalid = 1'b0;
    logic         o_m_axi_rx_tready;
    logic         uio_rs_vld;
    logic [127:0] uio_rs_data;
    logic         uio_rs_rdy = 1'b0;
    logic         o_rx_err;

    always #5 clk = ~clk;

    uio_axi_pkt_conv dut (
        .clk(clk), .reset_n(reset_n), .i_stat_chan_up(i_stat_chan_up),
        .uio_rq_vld(uio_rq_vld), .uio_rq_data(uio_rq_data), .uio_rq_afull(uio_rq_afull),
        .o_s_axi_tx_tdata(o_s_axi_tx_tdata), .o_s_axi_tx_tkeep(o_s_axi_tx_tkeep),
        .o_s_axi_tx_tlast(o_s_axi_tx_tlast), .o_s_axi_tx_tvalid(o_s_axi_tx_tvalid),
        .i_s_axi_tx_tready(i_s_axi_tx_tready),
        .i_m_axi_rx_tdata(i_m_axi_rx_tdata), .i_m_axi_rx_tkeep(i_m_axi_rx_tkeep),
        .i_m_axi_rx_tlast(i_m_axi_rx_tlast), .i_m_axi_rx_tvalid(i_m_axi_rx_tvalid),
        .o_m_axi_rx_tready(o_m_axi_rx_tready),
        .uio_rs_vld(uio_rs_vld), .uio_rs_data(uio_rs_data), .uio_rs_rdy(uio_rs_rdy),
        .o_rx_err(o_rx_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tx beats still owed (two per stored word), response words queued,
    // plus the rx framing position.
    logic [63:0]  txq[$];
    logic [127:0] rsq[$];
    int           tx_acc;
    logic [63:0]  part0;
    int           rx_k, rx_cnt;
    bit           err_pend;

    logic [63:0]  tx_log_d[$];
    bit           tx_log_l[$];
    logic [127:0] rs_log[$];
    int           err_cnt = 0;

    function automatic void model_clear();
        txq.delete();
        rsq.delete();
        tx_acc   = 0;
        part0    = '0;
        rx_k     = 0;
        rx_cnt   = 0;
        err_pend = 1'b0;
    endfunction

    initial model_clear();

    int          words;
    bit          e_tv, e_tl, e_af, e_rr, e_rv, pop_word, bad, err_next;
    logic [63:0] e_td;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_td;
    bit          prev_tl;

    always @(negedge clk) begin
        if (!reset_n) begin
            model_clear();
            prev_stall = 1'b0;
            chk("rst_tvalid", o_s_axi_tx_tvalid, 0);
            chk("rst_tlast", o_s_axi_tx_tlast, 0);
            chk("rst_tkeep", o_s_axi_tx_tkeep, 0);
            chk("rst_tdata", o_s_axi_tx_tdata, 0);
            chk("rst_rx_tready", o_m_axi_rx_tready, 0);
            chk("rst_rs_vld", uio_rs_vld, 0);
            chk("rst_rx_err", o_rx_err, 0);
            chk("rst_afull", uio_rq_afull, 1);
        end else begin
            words = (txq.size() + 1) / 2;
            e_tv  = (txq.size() > 0);
            e_td  = e_tv ? txq[0] : 64'h0;
            e_tl  = e_tv && (tx_acc % 8 == 7);
            e_af  = (16 - words <= 4) || !i_stat_chan_up;
            e_rr  = (16 - rsq.size() > 4) && i_stat_chan_up;
            e_rv  = (rsq.size() > 0);
            chk("tx_tvalid", o_s_axi_tx_tvalid, e_tv);
            chk("tx_tdata", o_s_axi_tx_tdata, e_td);
            chk("tx_tkeep", o_s_axi_tx_tkeep, e_tv ? 8'hFF : 8'h00);
            chk("tx_tlast", o_s_axi_tx_tlast, e_tl);
            chk("rq_afull", uio_rq_afull, e_af);
            chk("rx_tready", o_m_axi_rx_tready, e_rr);
            chk("rs_vld", uio_rs_vld, e_rv);
            if (e_rv) chk("rs_data", uio_rs_data, rsq[0]);
            chk("rx_err", o_rx_err, err_pend);
            if (prev_stall && i_stat_chan_up) begin
                chk("stall_tvalid", o_s_axi_tx_tvalid, 1);
                chk("stall_tdata", o_s_axi_tx_tdata, prev_td);
                chk("stall_tlast", o_s_axi_tx_tlast, prev_tl);
            end
            prev_stall = o_s_axi_tx_tvalid && !i_s_axi_tx_tready && i_stat_chan_up;
            prev_td    = o_s_axi_tx_tdata;
            prev_tl    = o_s_axi_tx_tlast;

            if (o_s_axi_tx_tvalid && i_s_axi_tx_tready) begin
                tx_log_d.push_back(o_s_axi_tx_tdata);
                tx_log_l.push_back(o_s_axi_tx_tlast);
            end
            if (uio_rs_vld && uio_rs_rdy) rs_log.push_back(uio_rs_data);
            if (o_rx_err) err_cnt++;

            err_next = 1'b0;
            if (!i_stat_chan_up) begin
                model_clear();
            end else begin
                pop_word = 1'b0;
                if (e_tv && i_s_axi_tx_tready) begin
                    pop_word = (txq.size() % 2 == 1);
                    txq.delete(0);
                    tx_acc++;
                end
                if (uio_rq_vld && (words < 16 || pop_word)) begin
                    txq.push_back(uio_rq_data[63:0]);
                    txq.push_back(uio_rq_data[127:64]);
                end
                if (e_rv && uio_rs_rdy) rsq.delete(0);
                if (i_m_axi_rx_tvalid && e_rr) begin
                    bad = (i_m_axi_rx_tlast != (rx_cnt == 7)) || (i_m_axi_rx_tkeep != 8'hFF);
                    if (rx_k == 0) part0 = i_m_axi_rx_tdata;
                    else rsq.push_back({i_m_axi_rx_tdata, part0});
                    rx_k   = 1 - rx_k;
                    rx_cnt = (rx_cnt + 1) % 8;
                    if (bad) begin
                        rx_k     = 0;
                        rx_cnt   = 0;
                        part0    = '0;
                        err_next = 1'b1;
                    end
                end
            end
            err_pend = err_next;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic flush_link();
        i_stat_chan_up = 1'b0;
        tick();
        i_stat_chan_up = 1'b1;
        tick();
        tx_log_d.delete();
        tx_log_l.delete();
        rs_log.delete();
        err_cnt = 0;
    endtask

    task automatic push_word(input logic [127:0] w);
        uio_rq_vld  = 1'b1;
        uio_rq_data = w;
        tick();
        uio_rq_vld  = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic l, input logic [7:0] k);
        int  t;
        bit  acc;
        t = 0;
        i_m_axi_rx_tvalid = 1'b1;
        i_m_axi_rx_tdata  = d;
        i_m_axi_rx_tlast  = l;
        i_m_axi_rx_tkeep  = k;
        while (1) begin
            @(negedge clk);
            acc = o_m_axi_rx_tready;
            tick();
            if (acc) break;
            t++;
            if (t > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rx_accept_timeout: beat %h not accepted within 200 cycles", d);
                break;
            end
        end
        i_m_axi_rx_tvalid = 1'b0;
    endtask

    localparam logic [63:0] B1 = 64'h1111_0000_0000_0000;
    localparam logic [63:0] B2 = 64'h2222_0000_0000_0000;
    localparam logic [63:0] B3 = 64'h3333_0000_0000_0000;
    localparam logic [63:0] B4 = 64'h4444_0000_0000_0000;
    localparam logic [63:0] B5 = 64'h5555_0000_0000_0000;
    localparam logic [63:0] B6 = 64'h6666_0000_0000_0000;

    initial begin
        reset_n = 1'b0;
        ticks(3);
        reset_n = 1'b1;
        tick();

        // Four words, sink always ready: first beat visible one cycle after first push.
        tx_log_d.delete(); tx_log_l.delete();
        i_s_axi_tx_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            uio_rq_vld  = 1'b1;
            uio_rq_data = {B1 + 64'(2*i+1), B1 + 64'(2*i)};
            @(negedge clk);
            if (i == 0) chk("first_push_tvalid_early", o_s_axi_tx_tvalid, 0);
            if (i == 1) begin
                chk("first_push_tvalid", o_s_axi_tx_tvalid, 1);
                chk("first_beat_data", o_s_axi_tx_tdata, B1);
            end
            tick();
        end
        uio_rq_vld = 1'b0;
        ticks(12);
        chk("burst_beats", tx_log_d.size(), 8);
        for (int k = 0; k < 8 && k < tx_log_d.size(); k++) begin
            chk("burst_data", tx_log_d[k], B1 + 64'(k));
            chk("burst_tlast", tx_log_l[k], (k == 7));
        end

        // Sink toggling ready every cycle.
        flush_link();
        i_s_axi_tx_tready = 1'b0;
        for (int i = 0; i < 4; i++) push_word({B2 + 64'(2*i+1), B2 + 64'(2*i)});
        for (int c = 0; c < 24; c++) begin
            i_s_axi_tx_tready = (c % 2 == 0);
            tick();
        end
        chk("toggle_beats", tx_log_d.size(), 8);
        for (int k = 0; k < 8 && k < tx_log_d.size(); k++) begin
            chk("toggle_data", tx_log_d[k], B2 + 64'(k));
            chk("toggle_tlast", tx_log_l[k], (k == 7));
        end

        // Overfill the request FIFO with the sink stalled.
        flush_link();
        i_s_axi_tx_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            uio_rq_vld  = 1'b1;
            uio_rq_data = {B1 + 64'(2*i+1), B1 + 64'(2*i)};
            @(negedge clk);
            chk("fill_afull", uio_rq_afull, (i >= 12));
            tick();
        end
        uio_rq_vld = 1'b0;
        i_s_axi_tx_tready = 1'b1;
        ticks(40);
        chk("fill_beats", tx_log_d.size(), 32);
        for (int k = 0; k < 32 && k < tx_log_d.size(); k++)
            chk("fill_data", tx_log_d[k], B1 + 64'(k));

        // Response backpressure: 12 stored words closes rx_tready.
        flush_link();
        uio_rs_rdy = 1'b0;
        for (int j = 0; j < 24; j++) send_beat(B3 + 64'(j), (j % 8 == 7), 8'hFF);
        ticks(2);
        @(negedge clk);
        chk("rs_full_tready", o_m_axi_rx_tready, 0);
        chk("rs_full_vld", uio_rs_vld, 1);
        tick();
        i_m_axi_rx_tvalid = 1'b1;
        i_m_axi_rx_tdata  = B3 + 64'd24;
        i_m_axi_rx_tlast  = 1'b0;
        ticks(4);
        uio_rs_rdy = 1'b1;
        for (int j = 24; j < 32; j++) send_beat(B3 + 64'(j), (j % 8 == 7), 8'hFF);
        ticks(20);
        chk("rs_words", rs_log.size(), 16);
        for (int i = 0; i < 16 && i < rs_log.size(); i++)
            chk("rs_order", rs_log[i], {B3 + 64'(2*i+1), B3 + 64'(2*i)});

        // Early tlast on beat 3 triggers a framing error and resync.
        flush_link();
        uio_rs_rdy = 1'b1;
        for (int j = 0; j < 12; j++) send_beat(B4 + 64'(j), (j == 3) || (j == 11), 8'hFF);
        ticks(6);
        chk("err_pulses", err_cnt, 1);
        chk("err_words", rs_log.size(), 6);
        if (rs_log.size() >= 3) begin
            chk("err_word1", rs_log[1], {B4 + 64'd3, B4 + 64'd2});
            chk("err_resync_word", rs_log[2], {B4 + 64'd5, B4 + 64'd4});
        end

        // Link drop mid-packet.
        flush_link();
        i_s_axi_tx_tready = 1'b0;
        for (int i = 0; i < 4; i++) push_word({B5 + 64'(2*i+1), B5 + 64'(2*i)});
        i_s_axi_tx_tready = 1'b1;
        ticks(3);
        i_stat_chan_up = 1'b0;
        tick();
        i_stat_chan_up = 1'b1;
        @(negedge clk);
        chk("drop_tvalid", o_s_axi_tx_tvalid, 0);
        chk("drop_rs_vld", uio_rs_vld, 0);
        tick();
        tx_log_d.delete(); tx_log_l.delete();
        for (int i = 0; i < 4; i++) push_word({B6 + 64'(2*i+1), B6 + 64'(2*i)});
        ticks(12);
        chk("drop_beats", tx_log_d.size(), 8);
        for (int k = 0; k < 8 && k < tx_log_d.size(); k++) begin
            chk("drop_data", tx_log_d[k], B6 + 64'(k));
            chk("drop_tlast", tx_log_l[k], (k == 7));
        end

        // Randomized traffic with occasional link drops, framing faults and a reset.
        for (int c = 0; c < 3000; c++) begin
            uio_rq_vld        = ($urandom_range(0, 99) < 50);
            uio_rq_data       = {$urandom, $urandom, $urandom, $urandom};
            i_s_axi_tx_tready = ($urandom_range(0, 99) < 60);
            uio_rs_rdy        = ($urandom_range(0, 99) < 50);
            i_m_axi_rx_tvalid = ($urandom_range(0, 99) < 60);
            i_m_axi_rx_tdata  = {$urandom, $urandom};
            i_m_axi_rx_tlast  = (rx_cnt == 7) ^ ($urandom_range(0, 99) < 3);
            i_m_axi_rx_tkeep  = ($urandom_range(0, 99) < 2) ? 8'h7F : 8'hFF;
            i_stat_chan_up    = ($urandom_range(0, 199) != 0);
            reset_n           = !(c == 1500 || c == 1501);
            tick();
        end

        reset_n = 1'b1;
        i_stat_chan_up = 1'b1;
        uio_rq_vld = 1'b0;
        i_m_axi_rx_tvalid = 1'b0;
        i_s_axi_tx_tready = 1'b1;
        uio_rs_rdy = 1'b1;
        ticks(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
